fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Time-multiplexed FIR controller: computes an NTAPS-tap FIR on one external multadd (single DSP).
//  Holds the sample delay line and coefficient bank, and steps the MAC once per tap.
//  Returns one output per accepted sample over valid/ready handshakes.
//  Sits between the sample stream source and the FIR output sink.
// PARAMETERS
//  DWIDTH    16  signed sample width (multadd AWIDTH)
//  CWIDTH    16  signed coefficient width (multadd BWIDTH)
//  NTAPS      8  number of taps, >=2, any integer (not restricted to powers of two)
//  ACC_WIDTH 40  accumulator width (multadd PIN_WIDTH = POUT_WIDTH); must be >= DWIDTH+CWIDTH+clog2(NTAPS)
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  s_valid    in   1          input sample valid
//  s_ready    out  1          input sample ready
//  s_data     in   DWIDTH     signed input sample
//  m_valid    out  1          output result valid
//  m_ready    in   1          output result ready
//  m_data     out  ACC_WIDTH  signed filter output
//  coef_we    in   1          coefficient write strobe
//  coef_addr  in   clog2(NTAPS)  tap index
//  coef_data  in   CWIDTH     signed coefficient
//  coef_busy  out  1          1 = coefficient writes are ignored this cycle
//  mac_rst    out  1          to multadd rst; equals rst (combinational)
//  mac_ce     out  1          to multadd ce
//  mac_a      out  DWIDTH     to multadd a_in (sample)
//  mac_b      out  CWIDTH     to multadd b_in (coefficient)
//  mac_p_in   out  ACC_WIDTH  to multadd p_in
//  mac_p_out  in   ACC_WIDTH  from multadd p_out; 1-cycle registered latency
// BEHAVIOUR
//  Reset values
//   - State = IDLE.
//   - s_ready=1, m_valid=0, m_data=0, coef_busy=0, mac_ce=0.
//   - Delay line, coefficients, wr_ptr and tap counter k all cleared to 0.
//  FSM: IDLE -> RUN -> DONE -> OUT -> IDLE
//   - IDLE: s_ready=1. On s_valid&&s_ready:
//       wr_ptr <= (wr_ptr+1) mod NTAPS; dline[new wr_ptr] <= s_data; k <= 0; go to RUN.
//   - RUN: s_ready=0, mac_ce=1 for exactly NTAPS cycles, k = 0..NTAPS-1.
//       mac_a = dline[(wr_ptr-k) mod NTAPS] (wrap handled explicitly).
//       mac_b = coef[k].
//       mac_p_in = 0 when k==0, else mac_p_out.
//       After k==NTAPS-1, go to DONE.
//   - DONE: one cycle, mac_ce=0. m_data <= mac_p_out (full sum); go to OUT.
//   - OUT: m_valid=1; m_data held stable until m_ready. On m_valid&&m_ready go to IDLE.
//       s_ready is 0 in OUT; there is no overlap between samples.
//  Combinational outputs: mac_a, mac_b and mac_p_in are don't-care when mac_ce=0.
//  Latency: sample accepted in cycle T -> m_valid rises in cycle T+NTAPS+2.
//  Throughput: at most one sample per NTAPS+3 cycles.
//  Arithmetic
//   - Signed throughout; mac_p_out is fed back unmodified.
//   - No rounding or saturation; the ACC_WIDTH rule guarantees no overflow.
//  Coefficients
//   - coef_we writes coef[coef_addr] in IDLE or OUT only.
//   - coef_busy=1 in RUN and DONE; writes in those states are dropped silently.
//   - coef_addr >= NTAPS is ignored.
//   - A coefficient written in IDLE in the same cycle a sample is accepted is used by that sample.
//  Delay line
//   - Holds the NTAPS newest samples; initial history is zeros.
//   - wr_ptr wraps from NTAPS-1 to 0.
//  Reset mid-operation: rst in any state aborts immediately to reset values.
//   - An in-flight result is discarded.
//   - mac_rst clears the multadd in the same cycle.
// TESTING
//  1 Impulse: coef[k]=k+1, samples 1,0x8 -> outputs 1,2,3,4,5,6,7,8,0.
//  2 Backpressure: hold m_ready=0 for 20 cycles after m_valid -> m_data stable, s_ready=0 throughout.
//      Release -> exactly one transfer, then s_ready=1 next cycle.
//  3 Coef write during RUN: write coef[0]=100 mid-RUN -> ignored; that output and the next are unchanged.
//  4 Extremes: all coefs and samples = -32768 after 8 samples -> m_data = 8*2^30 = 0x0200000000.
//  5 Reset mid-RUN at k=3 -> m_valid never asserts, state IDLE.
//      Next sample 5 with coef[0]=1 -> output 5 (history zeroed).
//  6 Wrap: random coefs and 50 random samples with random m_ready -> matches golden FIR model.
//      Latency is exactly NTAPS+2 from accept to m_valid.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller driving one external registered multiply-add.
// Holds the delay line and coefficient bank; one MAC step per tap, one result per sample.
module fir_mac_sequencer #(
  parameter int DWIDTH    = 16,
  parameter int CWIDTH    = 16,
  parameter int NTAPS     = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DWIDTH-1:0]     s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [ACC_WIDTH-1:0]  m_data,
  input  logic                         coef_we,
  input  logic [$clog2(NTAPS)-1:0]     coef_addr,
  input  logic signed [CWIDTH-1:0]     coef_data,
  output logic                         coef_busy,
  output logic                         mac_rst,
  output logic                         mac_ce,
  output logic signed [DWIDTH-1:0]     mac_a,
  output logic signed [CWIDTH-1:0]     mac_b,
  output logic signed [ACC_WIDTH-1:0]  mac_p_in,
  input  logic signed [ACC_WIDTH-1:0]  mac_p_out
);

  localparam int              AW   = $clog2(NTAPS);
  localparam logic [AW-1:0]   LAST = AW'(NTAPS - 1);
  localparam logic [AW:0]     NT   = (AW + 1)'(NTAPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE, OUT} state_t;

  state_t                      state_q;
  logic signed [DWIDTH-1:0]    dline_q [NTAPS];
  logic signed [CWIDTH-1:0]    coef_q  [NTAPS];
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, k_q, rd_idx;
  logic signed [ACC_WIDTH-1:0] m_data_q;
  logic                        coef_wr_ok;

  // Read index walks backwards from the newest sample; the +NTAPS term
  // covers the wrap for non-power-of-two tap counts.
  always_comb begin
    wr_ptr_d   = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    rd_idx     = (k_q > wr_ptr_q) ? AW'({1'b0, wr_ptr_q} + NT - {1'b0, k_q})
                                  : wr_ptr_q - k_q;
    coef_wr_ok = coef_we && (state_q == IDLE || state_q == OUT) &&
                 ({1'b0, coef_addr} < NT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      k_q      <= '0;
      m_data_q <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (coef_wr_ok) coef_q[coef_addr] <= coef_data;
      case (state_q)
        IDLE: if (s_valid) begin
          wr_ptr_q          <= wr_ptr_d;
          dline_q[wr_ptr_d] <= s_data;
          k_q               <= '0;
          state_q           <= RUN;
        end
        RUN: begin
          k_q <= k_q + 1'b1;
          if (k_q == LAST) state_q <= DONE;
        end
        DONE: begin
          m_data_q <= mac_p_out;
          state_q  <= OUT;
        end
        OUT: if (m_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign m_valid   = (state_q == OUT);
  assign coef_busy = (state_q == RUN) || (state_q == DONE);
  assign mac_ce    = (state_q == RUN);
  assign mac_rst   = rst;
  assign mac_a     = dline_q[rd_idx];
  assign mac_b     = coef_q[k_q];
  assign mac_p_in  = (k_q == '0) ? '0 : mac_p_out;
  assign m_data    = m_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with a behavioural registered multadd.
module tb_fir_mac_sequencer;
  localparam int NT = 8;

  logic clk = 0;
  logic rst, s_valid, s_ready, m_valid, m_ready, coef_we, coef_busy;
  logic mac_rst, mac_ce;
  logic signed [15:0] s_data, coef_data, mac_a, mac_b;
  logic [2:0] coef_addr;
  logic signed [39:0] m_data, mac_p_in, mac_p_out;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.DWIDTH(16), .CWIDTH(16), .NTAPS(NT), .ACC_WIDTH(40)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy),
    .mac_rst(mac_rst), .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b),
    .mac_p_in(mac_p_in), .mac_p_out(mac_p_out));

  // Registered multiply-add, one cycle latency.
  always @(posedge clk) begin
    if (mac_rst) mac_p_out <= '0;
    else if (mac_ce) mac_p_out <= mac_p_in + mac_a * mac_b;
  end

  logic mr_rand = 0, mr_fix = 1, rnd_bit = 0;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign m_ready = mr_rand ? rnd_bit : mr_fix;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [39:0] exp_q[$];
  int acc_q[$];
  logic signed [15:0] hist [NT];
  logic signed [15:0] coefm [NT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin hist[i] = '0; coefm[i] = '0; end
  endfunction

  function automatic logic signed [39:0] model_step(input logic signed [15:0] d);
    logic signed [39:0] acc = '0;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    for (int i = 0; i < NT; i++) acc += hist[i] * coefm[i];
    return acc;
  endfunction

  // Monitor: latency from accept to m_valid rise, and data on each transfer.
  logic prev_mv = 0;
  int a_cyc;
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_mv = 0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back(cyc);
      if (m_valid && !prev_mv) begin
        if (acc_q.size() == 0) check("latency_no_accept", 0, 1);
        else begin
          a_cyc = acc_q.pop_front();
          check("latency", 64'(cyc - a_cyc), 64'(NT + 2));
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 0, 1);
        else check("m_data", m_data, exp_q.pop_front());
      end
      prev_mv = m_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 400) begin @(negedge clk); n++; end
    if (!s_ready) check("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic write_coef(input int a, input logic signed [15:0] d);
    wait_idle();
    coef_we = 1; coef_addr = 3'(a); coef_data = d;
    coefm[a] = d;
    tick();
    coef_we = 0;
  endtask

  // use_hand selects the hand-computed value over the model; push=0 expects no output.
  task automatic send(input logic signed [15:0] d, input logic signed [39:0] hand,
                      input bit use_hand, input bit push);
    int n = 0;
    logic signed [39:0] y;
    s_valid = 1; s_data = d;
    @(negedge clk);
    while (!s_ready && n < 400) begin @(negedge clk); n++; end
    if (!s_ready) begin
      check("accept_timeout", 0, 1);
      s_valid = 0;
      return;
    end
    y = model_step(d);
    if (push) exp_q.push_back(use_hand ? hand : y);
    tick();
    s_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain", 64'(exp_q.size()), 0);
    wait_idle();
  endtask

  task automatic pulse_reset();
    rst = 1; tick(); rst = 0;
    model_reset();
  endtask

  initial begin
    int n;
    rst = 1; s_valid = 0; s_data = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mac_rst", mac_rst, 1);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_coef_busy", coef_busy, 0);
    check("rst_mac_ce", mac_ce, 0);
    tick(); rst = 0;

    // Impulse response
    for (int k = 0; k < NT; k++) write_coef(k, 16'(k + 1));
    send(16'sd1, 40'sd1, 1, 1);
    for (int i = 1; i < NT; i++) send(16'sd0, 40'(i + 1), 1, 1);
    send(16'sd0, 40'sd0, 1, 1);
    drain();

    // Backpressure
    mr_fix = 0;
    send(16'sd3, 40'sd3, 1, 1);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_m_valid_rise", m_valid, 1);
    repeat (20) begin
      @(negedge clk);
      check("bp_m_data", m_data, 40'sd3);
      check("bp_m_valid", m_valid, 1);
      check("bp_s_ready", s_ready, 0);
    end
    tick(); mr_fix = 1;
    tick(); mr_fix = 0;
    @(negedge clk);
    check("bp_after_m_valid", m_valid, 0);
    check("bp_after_s_ready", s_ready, 1);
    mr_fix = 1;
    drain();

    // Coefficient write during RUN is dropped
    send(16'sd7, 40'sd13, 1, 1);
    tick(); tick();
    coef_we = 1; coef_addr = 3'd0; coef_data = 16'sd100;
    @(negedge clk);
    check("run_coef_busy", coef_busy, 1);
    tick();
    coef_we = 0;
    send(16'sd2, 40'sd25, 1, 1);
    drain();

    // Extremes
    pulse_reset();
    for (int k = 0; k < NT; k++) write_coef(k, -16'sd32768);
    for (int i = 1; i <= NT; i++) send(-16'sd32768, 40'sd1073741824 * i, 1, 1);
    drain();

    // Reset mid-RUN at k=3
    send(16'sd9, 40'sd0, 1, 0);
    tick(); tick(); tick();
    pulse_reset();
    repeat (15) begin
      @(negedge clk);
      check("abort_m_valid", m_valid, 0);
      check("abort_s_ready", s_ready, 1);
    end
    write_coef(0, 16'sd1);
    send(16'sd5, 40'sd5, 1, 1);
    drain();

    // Random coefficients/samples with random backpressure
    mr_rand = 1;
    for (int k = 0; k < NT; k++) write_coef(k, 16'($urandom));
    for (int i = 0; i < 50; i++) send(16'($urandom), 40'sd0, 0, 1);
    drain();
    mr_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
